// File: rtl/i4004_cycle_seq_pkg.sv
// MCS-4 shared types: instruction sub-cycle encoding and the opcodes
// that identify double-word instructions.
package mcs4;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    localparam logic [3:0] OPR_JCN = 4'd1;
    localparam logic [3:0] OPR_FIM = 4'd2;
    localparam logic [3:0] OPR_JUN = 4'd4;
    localparam logic [3:0] OPR_JMS = 4'd5;
    localparam logic [3:0] OPR_ISZ = 4'd7;

    function automatic instr_cyc_t next_cyc(input instr_cyc_t cyc);
        logic [2:0] raw;
        raw = cyc;
        return instr_cyc_t'(raw + 3'd1);
    endfunction

endpackage

// File: rtl/i4004_cycle_seq_dword_detect.sv
// Combinational classifier: does the fetched word start a two-word instruction?
module i4004_dword_detect
    import mcs4::*;
(
    input  logic [3:0] opr,
    input  logic       opa0,
    input  logic       second_word,
    output logic       dword
);

    // A second word is never itself the start of another double word.
    always_comb begin
        dword = 1'b0;
        if (!second_word) begin
            case (opr)
                OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: dword = 1'b1;
                OPR_FIM: dword = ~opa0;
                default: dword = 1'b0;
            endcase
        end else begin
            dword = 1'b0;
        end
    end

endmodule

// File: rtl/i4004_cycle_seq.sv
// i4004 instruction cycle sequencer: A1..X3 sub-cycles of two clocks each.
// Optional stop/halt behaviour is enabled by defining I4004_STOP_EN.
module i4004_cycle_seq
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stop,
    input  logic [3:0] dbus_in,
    output instr_cyc_t icyc,
    output logic       clken_1,
    output logic       clken_2,
    output logic       sync,
    output logic       second_word,
    output logic       opr_ld,
    output logic       opa_ld,
    output logic       exec_en,
    output logic       pc_inc,
    output logic       stopped
);

    instr_cyc_t cyc_q, cyc_d;
    logic       phase_q, phase_d;
    logic       second_word_q, second_word_d;
    logic       stopped_q, stopped_d;
    logic [3:0] opr_q, opr_d;
    logic       opa0_q, opa0_d;
    logic       dword_pending_s;
    logic       stop_req_s;
    logic       running_s;

`ifdef I4004_STOP_EN
    assign stop_req_s = stop;
`else
    logic unused_stop_s;
    assign unused_stop_s = stop;
    assign stop_req_s    = 1'b0;
`endif

    // Latched OPR/OPA hold still from M2 end through X3, so the decode is valid there.
    i4004_dword_detect u_dword_detect (
        .opr         (opr_q),
        .opa0        (opa0_q),
        .second_word (second_word_q),
        .dword       (dword_pending_s)
    );

    assign running_s = ~stopped_q;

    // Next-state: advance phase every clk, sub-cycle on phase 1, handle halt.
    always_comb begin
        cyc_d         = cyc_q;
        phase_d       = phase_q;
        second_word_d = second_word_q;
        stopped_d     = stopped_q;
        opr_d         = opr_q;
        opa0_d        = opa0_q;
        if (stopped_q) begin
            stopped_d = stop_req_s;
        end else if (phase_q) begin
            phase_d = 1'b0;
            cyc_d   = next_cyc(cyc_q);
            case (cyc_q)
                M1: opr_d  = dbus_in;
                M2: opa0_d = dbus_in[0];
                X3: begin
                    if (stop_req_s && !dword_pending_s) begin
                        stopped_d     = 1'b1;
                        second_word_d = 1'b0;
                    end else begin
                        second_word_d = dword_pending_s;
                    end
                end
                default: cyc_d = next_cyc(cyc_q);
            endcase
        end else begin
            phase_d = 1'b1;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q         <= A1;
            phase_q       <= 1'b0;
            second_word_q <= 1'b0;
            stopped_q     <= 1'b0;
            opr_q         <= 4'd0;
            opa0_q        <= 1'b0;
        end else begin
            cyc_q         <= cyc_d;
            phase_q       <= phase_d;
            second_word_q <= second_word_d;
            stopped_q     <= stopped_d;
            opr_q         <= opr_d;
            opa0_q        <= opa0_d;
        end
    end

    // Output decode straight from state flops.
    always_comb begin
        icyc        = cyc_q;
        clken_1     = running_s & ~phase_q;
        clken_2     = running_s & phase_q;
        sync        = running_s & (cyc_q == X3);
        second_word = second_word_q;
        opr_ld      = running_s & phase_q & (cyc_q == M1);
        opa_ld      = running_s & phase_q & (cyc_q == M2);
        pc_inc      = running_s & phase_q & (cyc_q == X3);
        exec_en     = 1'b0;
        if (running_s && ((cyc_q == X1) || (cyc_q == X2) || (cyc_q == X3))) begin
            exec_en = ~dword_pending_s;
        end else begin
            exec_en = 1'b0;
        end
`ifdef I4004_STOP_EN
        stopped = stopped_q;
`else
        stopped = 1'b0;
`endif
    end

endmodule

// File: tb/tb_i4004_cycle_seq.sv
// Self-checking bench for i4004_cycle_seq: clk-position reference model,
// directed passes plus randomized bus/stop stimulus.
module tb_i4004_cycle_seq;

`ifdef I4004_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic stop;
    logic [3:0] dbus_in;
    mcs4::instr_cyc_t icyc;
    logic clken_1, clken_2, sync, second_word, opr_ld, opa_ld, exec_en, pc_inc, stopped;

    i4004_cycle_seq dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .dbus_in(dbus_in),
        .icyc(icyc), .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .second_word(second_word), .opr_ld(opr_ld), .opa_ld(opa_ld),
        .exec_en(exec_en), .pc_inc(pc_inc), .stopped(stopped)
    );

    always #5 clk = ~clk;

    logic [11:0] dut_vec;
    assign dut_vec = {icyc, clken_1, clken_2, sync, second_word,
                      opr_ld, opa_ld, exec_en, pc_inc, stopped};

    int errors = 0;
    int checks = 0;

    // Reference model: clk position within a 16-clk pass plus instruction bookkeeping.
    int         m_k;
    bit         m_sw, m_pend, m_stop;
    logic [3:0] m_opr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_dword(input logic [3:0] opr, input bit opa0, input bit sw);
        if (sw) return 1'b0;
        if (opr inside {4'd1, 4'd4, 4'd5, 4'd7}) return 1'b1;
        if (opr == 4'd2) return !opa0;
        return 1'b0;
    endfunction

    function automatic logic [11:0] expect_vec();
        logic [2:0] cyc;
        if (m_stop) return 12'h001;
        cyc = 3'(m_k / 2);
        return {cyc, (m_k % 2) == 0, (m_k % 2) == 1, m_k >= 14, m_sw,
                m_k == 7, m_k == 9, (m_k >= 10) && !m_pend, m_k == 15, 1'b0};
    endfunction

    task automatic model_reset();
        m_k = 0; m_sw = 1'b0; m_pend = 1'b0; m_stop = 1'b0; m_opr = 4'd0;
    endtask

    task automatic model_edge(input logic [3:0] d, input bit s);
        if (m_stop) begin
            if (!s) m_stop = 1'b0;
        end else begin
            if (m_k == 7) m_opr = d;
            if (m_k == 9) m_pend = is_dword(m_opr, d[0], m_sw);
            if (m_k == 15) begin
                if (STOP_EN && s && !m_pend) begin
                    m_stop = 1'b1;
                    m_sw   = 1'b0;
                end else begin
                    m_sw = m_pend;
                end
            end
            m_k = (m_k + 1) % 16;
        end
    endtask

    task automatic step(input logic [3:0] d, input bit s, input string tag);
        dbus_in = d;
        stop    = s;
        @(posedge clk);
        if (rst_n) model_edge(d, s);
        #1;
        check_val(tag, dut_vec, expect_vec());
    endtask

    // One 16-clk pass: OPR nibble on the bus during A1..M1, OPA nibble afterwards.
    task automatic run_pass(input logic [3:0] opr, input logic [3:0] opa, input bit s, input string tag);
        for (int i = 0; i < 16; i++) begin
            step((m_k < 8) ? opr : opa, s, tag);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        stop    = 1'b0;
        dbus_in = 4'd0;
        model_reset();
        #12;
        check_val("reset_state", dut_vec, 12'h100);
        rst_n = 1'b1;

        run_pass(4'd0, 4'd0, 1'b0, "free_run");
        run_pass(4'd0, 4'd0, 1'b0, "free_run");

        run_pass(4'd4, 4'd0, 1'b0, "jun_w1");
        check_val("jun_sw_set", second_word, 1'b1);
        run_pass(4'd0, 4'd0, 1'b0, "jun_w2");
        check_val("jun_sw_clr", second_word, 1'b0);

        run_pass(4'd2, 4'd0, 1'b0, "fim_w1");
        check_val("fim_sw", second_word, 1'b1);
        run_pass(4'd0, 4'd0, 1'b0, "fim_w2");
        run_pass(4'd2, 4'd1, 1'b0, "src");
        check_val("src_sw", second_word, 1'b0);

        if (STOP_EN) begin
            run_pass(4'd2, 4'd1, 1'b1, "stop_single");
            check_val("stop_stopped", stopped, 1'b1);
            for (int i = 0; i < 3; i++) step(4'd0, 1'b1, "stop_hold");
            step(4'd0, 1'b0, "stop_release");
            check_val("release_clken1", clken_1, 1'b1);
            run_pass(4'd5, 4'd0, 1'b1, "jms_w1_stop");
            check_val("jms_not_stopped", stopped, 1'b0);
            run_pass(4'd0, 4'd0, 1'b1, "jms_w2_stop");
            check_val("jms_then_stopped", stopped, 1'b1);
            step(4'd0, 1'b0, "jms_release");
        end else begin
            run_pass(4'd2, 4'd1, 1'b1, "stop_ignored");
            check_val("stop_ignored_flag", stopped, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), $urandom_range(0, 7) == 0, "random");
        end

        for (int i = 0; i < 60; i++) begin
            if (!(m_k == 0 && !m_stop && !m_sw)) step(4'd0, 1'b0, "align");
        end
        check_val("align_done", (m_k == 0 && !m_stop && !m_sw), 1'b1);
        for (int i = 0; i < 12; i++) step(4'd4, 1'b0, "jun_pre_rst");
        check_val("jun_x2_exec", exec_en, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_async", dut_vec, 12'h100);
        step(4'd4, 1'b0, "rst_hold");
        rst_n = 1'b1;
        run_pass(4'd0, 4'd0, 1'b0, "post_rst");
        run_pass(4'd0, 4'd0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i4004_cycle_seq.md
I4004_CYCLE_SEQ -- requirements
Module: i4004_cycle_seq

Interface
REQ-001 SHALL: clk  input  1  system clock; every state change on its rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: stop  input  1  stop request, sampled only at end of X3.
REQ-004 SHALL: dbus_in  input  4  data bus nibble as seen by CPU.
REQ-005 SHALL: icyc  output  mcs4::instr_cyc_t (3)  current instruction sub-cycle A1..X3.
REQ-006 SHALL: clken_1  output  1  high on first clk of each sub-cycle.
REQ-007 SHALL: clken_2  output  1  high on second clk of each sub-cycle.
REQ-008 SHALL: sync  output  1  high on both clks of X3.
REQ-009 SHALL: second_word  output  1  current 8-sub-cycle pass fetches word 2 of a double-word instruction.
REQ-010 SHALL: opr_ld  output  1  one-clk strobe, capture OPR (M1, second clk).
REQ-011 SHALL: opa_ld  output  1  one-clk strobe, capture OPA (M2, second clk).
REQ-012 SHALL: exec_en  output  1  high through X1..X3 when the current word completes an instruction.
REQ-013 SHALL: pc_inc  output  1  one-clk strobe, advance PC (X3, second clk).
REQ-014 SHALL: stopped  output  1  sequencer halted.

Function
REQ-015 SHALL: each sub-cycle lasts exactly 2 clks (phase 0 then 1); order A1,A2,A3,M1,M2,X1,X2,X3, wrap X3->A1; full pass 16 clks.
REQ-016 SHALL: clken_1 = running & phase0; clken_2 = running & phase1; never both high.
REQ-017 SHALL: OPR latched from dbus_in at M1 phase1; OPA bit0 latched at M2 phase1.
REQ-018 SHALL: at end of M2, dword_pending = !second_word & (OPR in {1 JCN, 4 JUN, 5 JMS, 7 ISZ} | (OPR==2 & OPA[0]==0, FIM)); SRC (OPR 2, OPA[0]=1) single-word.
REQ-019 SHALL: exec_en = !dword_pending during X1..X3.
REQ-020 SHALL: second_word loads dword_pending at end of X3; second word never sets dword_pending (max two words).
REQ-021 SHALL: pc_inc pulses once per pass, including second-word passes.
REQ-022 SHALL: stop=1 at end of X3 with dword_pending=0 -> STOPPED state: icyc=A1, clken_1/2, sync, strobes 0, stopped=1.
REQ-023 SHALL: stop=1 at end of X3 with dword_pending=1 -> ignored; re-sampled at end of the second word's X3.
REQ-024 SHALL: in STOPPED, stop=0 on a clk edge -> next clk A1 phase0, stopped=0.
REQ-025 SHALL: stop changes outside X3 phase1 / STOPPED have no effect.

Reset
REQ-026 SHALL: rst_n low at any time immediately forces icyc=A1, phase0, second_word=0, dword_pending=0, stopped=0, latched OPR/OPA=0.
REQ-027 SHALL: output values in reset: clken_1=1, clken_2=0, sync=0, opr_ld=0, opa_ld=0, exec_en=0, pc_inc=0, stopped=0.
REQ-028 SHALL: first edge after rst_n rises advances to A1 phase1; in-flight double word discarded.

Configuration
REQ-029 SHALL: macro I4004_STOP_EN defined -> REQ-022..REQ-024 active.
REQ-030 SHALL: macro absent -> stop port present but ignored; stopped tied 0; no STOPPED state.

Structure
REQ-031 SHALL: mcs4 package holds instr_cyc_t (A1=0..X3=7) and OPR codes JCN, FIM, JUN, JMS, ISZ.
REQ-032 SHALL: double-word detection in sub-module i4004_dword_detect (combinational: opr, opa0, second_word -> dword).

Verification
REQ-033 SHALL: free run, dbus_in=0 -> period 16 clks; sync on clks 14-15; pc_inc clk 15; exec_en clks 10-15.
REQ-034 SHALL: OPR=4 (JUN) pass -> exec_en 0, next pass second_word=1 and exec_en=1, third pass second_word=0.
REQ-035 SHALL: OPR=2 OPA=0 (FIM) -> second_word next pass; OPR=2 OPA=1 (SRC) -> no second word.
REQ-036 SHALL: [I4004_STOP_EN] stop=1 over single-word X3 -> stopped=1, clkens 0; drop stop -> A1 next clk.
REQ-037 SHALL: [I4004_STOP_EN] stop=1 during JMS first word -> second word completes, then stopped=1.
REQ-038 SHALL: rst_n low in X2 of a JUN first word -> immediate A1, second_word=0; release -> normal 16-clk passes.
